// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch unit.
// The optional perf counters are enabled with the FETCH_PERF_EN macro.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        OUT  = 2'd1,
        HALT = 2'd2
    } fetchState_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam int unsigned MIN_LATENCY = 1;
    localparam int unsigned MAX_LATENCY = 7;

    function automatic bit latencyOk(int unsigned lat);
        return (lat >= MIN_LATENCY) && (lat <= MAX_LATENCY);
    endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Memory latency counter; done marks the cycle the read word is sampled.
// Part of the FETCH_PERF_EN-configurable fetch unit.
module fetch_wait_counter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [2:0] LAST = 3'(MEM_LATENCY - 1);

    logic [2:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 3'd0;
        end else if (clear) begin
            count <= 3'd0;
        end else if (enable) begin
            count <= count + 3'd1;
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, waits on memory, hands words to decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] readAddress,
    input  logic [31:0] instruction,
    input  logic        fimDoArquivo,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    if (!latencyOk(MEM_LATENCY) || (RESET_PC[1:0] != 2'b00)) begin : gBadParam
        $error("instruction_fetch_unit: illegal MEM_LATENCY or RESET_PC");
    end

    fetchState_t state, nextState;
    logic [31:0] pc;
    logic        started;
    logic        cntDone, cntClear, cntEnable;
    logic        wordOk, aligned;
    logic        accept, endFetch, handshake;

    assign readAddress = pc;
    assign aligned     = (redirect_pc[1:0] == 2'b00);

    // The parity term is never true for an unknown word, so X reads halt.
    assign wordOk = (fimDoArquivo == 1'b0)
                 && (instruction != ZERO_WORD)
                 && (((^instruction) == 1'b0) || ((^instruction) == 1'b1));

    assign cntClear  = redirect_valid || (state != REQ);
    assign cntEnable = (state == REQ) && started && !cntDone;

    fetch_wait_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) waitCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cntClear),
        .enable(cntEnable),
        .done  (cntDone)
    );

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        endFetch  = 1'b0;
        handshake = 1'b0;
        unique case (state)
            REQ: begin
                if (started && cntDone) begin
                    if (wordOk) begin
                        accept    = 1'b1;
                        nextState = OUT;
                    end else begin
                        endFetch  = 1'b1;
                        nextState = HALT;
                    end
                end
            end
            OUT: begin
                if (if_ready) begin
                    handshake = 1'b1;
                    nextState = REQ;
                end
            end
            HALT: nextState = HALT;
            default: nextState = REQ;
        endcase
        if (redirect_valid) begin
            accept    = 1'b0;
            endFetch  = 1'b0;
            handshake = 1'b0;
            nextState = aligned ? REQ : HALT;
        end
    end

    // started holds the first request back one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= REQ;
            started      <= 1'b0;
            pc           <= RESET_PC;
            if_valid     <= 1'b0;
            if_instr     <= ZERO_WORD;
            if_pc        <= 32'd0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state   <= nextState;
            started <= 1'b1;
            if (redirect_valid) begin
                if_valid     <= 1'b0;
                halted       <= !aligned;
                misalign_err <= !aligned;
                if (aligned) begin
                    pc <= redirect_pc;
                end
            end else if (accept) begin
                if_instr <= instruction;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= pc + INSTR_BYTES;
            end else if (handshake) begin
                if_valid <= 1'b0;
            end else if (endFetch) begin
                halted <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (handshake) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state == OUT) && !if_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
